// File: rtl/otter_pipe_pkg.sv
// Shared types for the OTTER pipeline controller: FSM state encoding and
// operand-forward select codes used by the hazard controller and fwd_unit.
package otter_pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forward select for one EX ALU source. The youngest producer (MEM)
// wins over WB; x0 is never forwarded because it is hardwired to zero.
module fwd_unit
  import otter_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  // Pick the most recent in-flight writer of rs, else read the register file.
  always_comb begin
    sel = FWD_RF;
    if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) sel = FWD_WB;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) sel = FWD_MEM;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central control for the five-stage OTTER pipe: stage enables/flushes,
// PC hold, ALU operand forwarding and interrupt entry by draining the pipe.
// No datapath state lives here; only the FSM, drain counter and the
// saturating stall/flush event counters.
module pipe_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_use_rs1,
  input  logic             de_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             intr_req,
  input  logic             intr_en,
  output logic             pc_write,
  output logic             if_de_en,
  output logic             de_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_de_flush,
  output logic             de_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             intr_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       lu;
  logic       lu_eff;
  logic       stall_ev;
  logic       flush_ev;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  fwd_unit u_fwd_a (
    .rs            (de_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs            (de_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_raw)
  );

  assign fwd_a_sel = RESET_N ? fwd_a_raw : FWD_RF;
  assign fwd_b_sel = RESET_N ? fwd_b_raw : FWD_RF;

  // A load in EX feeding the DE instruction cannot be forwarded in time.
  assign lu = ex_mem_read && (ex_rd != 5'd0) &&
              ((de_use_rs1 && (ex_rd == de_rs1)) || (de_use_rs2 && (ex_rd == de_rs2)));

  // A redirect squashes the dependent instruction; in ACK the PC must load
  // mtvec, so a stall there is not applied.
  assign lu_eff = lu && !ex_redirect && (state != ACK);

  // Per-cycle stage control: freeze > redirect > load-use > run, then the
  // FSM overlays its PC hold / front-end flush / acknowledge.
  always_comb begin
    pc_write    = 1'b1;
    if_de_en    = 1'b1;
    de_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_de_flush = 1'b0;
    de_ex_flush = 1'b0;
    intr_ack    = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (!RESET_N) begin
      pc_write = 1'b1;
    end else if (mem_busy) begin
      pc_write  = 1'b0;
      if_de_en  = 1'b0;
      de_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else begin
      if (ex_redirect) begin
        if_de_flush = 1'b1;
        de_ex_flush = 1'b1;
        flush_ev    = 1'b1;
      end else if (lu_eff) begin
        pc_write    = 1'b0;
        if_de_en    = 1'b0;
        de_ex_flush = 1'b1;
        stall_ev    = 1'b1;
      end
      case (state)
        DRAIN: begin
          pc_write = 1'b0;
          // Keep a stalled DE instruction rather than flushing it away.
          if (!lu_eff) if_de_flush = 1'b1;
        end
        ACK: begin
          pc_write    = 1'b1;
          if_de_flush = 1'b1;
          intr_ack    = 1'b1;
        end
        default: begin
          pc_write = pc_write;
        end
      endcase
    end
  end

  // Interrupt entry sequencer: RUN -> DRAIN (count down) -> ACK -> RUN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
    end else if (!mem_busy) begin
      case (state)
        RUN: begin
          if (intr_req && intr_en && !ex_redirect && !lu) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!intr_req) begin
            state <= RUN;
          end else if (drain_cnt == 4'd0) begin
            state <= ACK;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        ACK: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Performance counters: one count per applied stall / redirect flush.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev) stall_cnt <= sat_inc(stall_cnt);
      if (flush_ev) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the five-stage OTTER core (IF, DE, EX, MEM, WB).
- Issues per-stage enable and flush signals to the four pipeline registers (IF/DE, DE/EX, EX/MEM, MEM/WB) and holds the PC.
- Selects forwarding paths for the EX ALU operands.
- Sequences interrupt entry by draining the pipe before acknowledging INTR. Purely control: no datapath registers.

Parameters:
- DRAIN_CYCLES, 3, cycles spent in DRAIN before the interrupt acknowledge (1..15).
- CNT_W, 16, width of the saturating stall/flush performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- de_rs1, de_rs2  in  5 each  source register addresses of the instruction in DE.
- de_use_rs1, de_use_rs2  in  1 each  DE instruction actually reads rs1 / rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_reg_write, ex_mem_read  in  1 each  EX instruction writes the RF / is a load.
- mem_rd, wb_rd  in  5 each  rd in MEM and in WB.
- mem_reg_write, wb_reg_write  in  1 each  write-enable in MEM and in WB.
- ex_redirect  in  1  EX resolved a taken branch or jump (pc_source != PC+4).
- mem_busy  in  1  data memory or IOBUS not ready; the whole pipe must freeze.
- intr_req  in  1  external interrupt, level.
- intr_en  in  1  interrupts enabled (CSR MIE).
- pc_write  out  1  PC register load enable.
- if_de_en, de_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_de_flush, de_ex_flush  out  1 each  synchronous bubble insert (clear valid/controls).
- fwd_a_sel, fwd_b_sel  out  2 each  00 = RF, 01 = EX/MEM result, 10 = MEM/WB wd.
- intr_ack  out  1  one-cycle pulse: pipe drained, CSR/PC may vector to mtvec.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Behaviour:
- Reset (async, RESET_N=0):
  - state=RUN, drain counter=0, counters=0.
  - All enables=1, flushes=0, fwd=00, intr_ack=0.
- Forwarding (combinational, independent of state):
  - Port A = 01 if mem_reg_write && mem_rd!=0 && mem_rd==de_rs1.
  - Otherwise 10 if wb_reg_write && wb_rd!=0 && wb_rd==de_rs1.
  - Otherwise 00. Port B is identical using de_rs2. MEM has priority over WB.
- Load-use hazard: lu = ex_mem_read && ex_rd!=0 && ((de_use_rs1 && ex_rd==de_rs1) || (de_use_rs2 && ex_rd==de_rs2)).
- Priority per cycle, highest first:
  1. mem_busy: all enables=0, pc_write=0, flushes=0. State, drain counter and counters hold (no count).
  2. ex_redirect: pc_write=1, all enables=1, if_de_flush=1, de_ex_flush=1. flush_cnt++. A simultaneous lu is ignored, because the dependent instruction is squashed.
  3. lu: pc_write=0, if_de_en=0, de_ex_flush=1, others enabled. stall_cnt++. Exactly one bubble, since the next cycle's lu is false.
  4. Otherwise all enables=1, pc_write=1, no flush.
- FSM states: RUN, DRAIN, ACK.
  - RUN -> DRAIN: when intr_req && intr_en && !mem_busy && !ex_redirect && !lu. Drain counter loads DRAIN_CYCLES-1.
  - DRAIN: pc_write=0, if_de_flush=1. Downstream stages advance normally.
    - A redirect in DRAIN is still flushed, but pc_write stays 0.
    - The counter decrements on non-busy cycles. At 0 -> ACK.
    - If intr_req deasserts during DRAIN, return to RUN next cycle (no ack). Drained bubbles are harmless.
  - ACK: intr_ack=1 for exactly one cycle, pc_write=1 (PC loads mtvec), if_de_flush=1. Then -> RUN.
  - mem_busy in ACK holds ACK and suppresses intr_ack until the first non-busy cycle. intr_ack therefore pulses exactly once.
- Counters saturate at all-ones and do not wrap.
- Reset mid-DRAIN/ACK returns immediately to RUN without an ack.

Decomposition:
- Shared package otter_pipe_pkg: enum state_t {RUN, DRAIN, ACK} and fwd_sel_t constants (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10).
- One sub-module fwd_unit (pure combinational operand-forward select, instanced once with rs1 and once with rs2).

Test Plan:
- After reset: intr_req=0, no hazards -> all enables=1, pc_write=1, fwd=00, counters=0.
- ex_rd=5, ex_mem_read=1, de_rs1=5, de_use_rs1=1 -> one cycle with pc_write=0, if_de_en=0, de_ex_flush=1; stall_cnt=1; next cycle normal.
- mem_rd=7 write, wb_rd=7 write, de_rs2=7 -> fwd_b_sel=01. Repeat with mem_rd=0 -> 10. Repeat with de_rs2=0 -> 00.
- ex_redirect=1 coincident with lu -> both flushes=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- intr_req=intr_en=1 with DRAIN_CYCLES=3 and mem_busy asserted for 2 cycles mid-drain -> intr_ack single pulse 6 cycles after the request is seen (1 entry + 3 drain + 2 busy).
- Force the counter to all-ones by repeated lu (CNT_W=4: 20 stalls) -> stall_cnt=15 held. Assert RESET_N=0 in DRAIN -> immediate RUN, counters 0, no intr_ack.
